branch_hazard_scoreboard: RTL and testbench
===========================================

BRANCH_HAZARD_SCOREBOARD -- requirements
Module: branch_hazard_scoreboard

Interface
REQ-001 SHALL have parameter NUM_SRC, default 2: number of ID-stage source operands checked.
REQ-002 SHALL have parameter DEPTH, default 3: number of tracked in-flight stages after ID (stage 0 = EX).
REQ-003 SHALL have parameter LOAD_READY, default 2: first stage index at which load data is forwardable.
REQ-004 SHALL have parameter ALU_READY, default 0: first stage index at which non-load results are forwardable.
REQ-005 SHALL have parameter CNT_W, default 16: width of the statistics counters.
REQ-006 SHALL use one clock and an asynchronous, active-high reset.
REQ-007 SHALL have port i_clk, input, 1: rising-edge clock.
REQ-008 SHALL have port i_rst, input, 1: asynchronous active-high reset.
REQ-009 SHALL have port i_id_rs, input, NUM_SRC*5: packed ID source register indices, operand n at bits [5n+4:5n].
REQ-010 SHALL have port i_id_rs_used, input, NUM_SRC: per-operand "operand is read" flag.
REQ-011 SHALL have port i_issue_valid, input, 1: ID instruction leaves ID this cycle.
REQ-012 SHALL have ports i_issue_rd (input, 5), i_issue_reg_write (input, 1) and i_issue_is_load (input, 1): destination attributes of the issuing instruction.
REQ-013 SHALL have port i_advance, input, 1: pipeline shifts this cycle.
REQ-014 SHALL have port i_flush, input, 1: squash the stage-0 entry.
REQ-015 SHALL have port o_fwd_sel, output, NUM_SRC*SEL_W, SEL_W=$clog2(DEPTH+1): 0 = register file, k = forward from stage k-1.
REQ-016 SHALL have port o_stall, output, 1: hold ID and insert a bubble.
REQ-017 SHALL have ports o_stall_cycles and o_fwd_events, output, CNT_W each: saturating statistics counters.

Function
REQ-018 SHALL keep a DEPTH-entry shift register; each entry holds {valid, rd, reg_write, is_load}.
REQ-019 On a cycle with i_advance=1, entry k SHALL load entry k-1 (k>=1), and entry 0 SHALL load the issuing instruction only when i_issue_valid=1 and o_stall=0; otherwise entry 0 SHALL load a bubble (valid=0).
REQ-020 With i_advance=0, all entries SHALL hold their values.
REQ-021 i_flush=1 SHALL clear entry 0 (valid=0) at the next edge; with i_advance=1 in the same cycle, the shift SHALL occur and entry 0 SHALL become a bubble; flush SHALL win over issue.
REQ-022 An entry SHALL match operand n when valid && reg_write && rd!=0 && rd==rs[n] && rs_used[n].
REQ-023 For each operand, only the youngest matching entry (lowest index) SHALL be considered; older matches SHALL be ignored.
REQ-024 The youngest match at index k SHALL be ready when k >= (is_load ? LOAD_READY : ALU_READY).
REQ-025 If the youngest match is ready, o_fwd_sel[n] SHALL be k+1; if there is no match, it SHALL be 0.
REQ-026 o_stall SHALL be 1 when any operand's youngest match is not ready; while stalling, all o_fwd_sel fields SHALL be 0.
REQ-027 o_fwd_sel and o_stall SHALL be combinational from the entry state and ID inputs, with zero-cycle latency.
REQ-028 o_stall_cycles SHALL increment on each edge where o_stall=1 && i_advance=1, and saturate at all-ones.
REQ-029 o_fwd_events SHALL increment by 1 on each edge where i_issue_valid && i_advance && !o_stall && any o_fwd_sel!=0, and saturate at all-ones.
REQ-030 rs=0 SHALL never match, stall or forward.

Reset
REQ-031 i_rst=1 SHALL immediately clear all entry valid bits and both counters, independent of the clock.
REQ-032 During reset, o_stall and all o_fwd_sel fields SHALL read 0.
REQ-033 Reset asserted mid-stall SHALL drop o_stall in the same cycle.
REQ-034 The first rising edge after reset deassertion SHALL behave as a normal cycle.

Structure
REQ-035 Shared package hazard_pkg SHALL hold: the SEL_W function, FWD_RF=0, and default DEPTH/LOAD_READY/ALU_READY values.
REQ-036 Sub-module hazard_src_match (one instance per operand) SHALL do the youngest-match search and readiness evaluation, outputting {sel, stall}.
REQ-037 The top level SHALL contain the shift register, the counters and the OR-reduction of stall.

Verification
REQ-038 ALU producer rd=5 issued, next-cycle rs1=5 (defaults) -> o_fwd_sel[0]=1, o_stall=0.
REQ-039 Load rd=7 issued, branch rs2=7 -> o_stall=1 for 2 advancing cycles, then o_fwd_sel[1]=3; o_stall_cycles=2.
REQ-040 rd=9 in stage 0 (ALU) and stage 2 (ALU), rs1=9 -> o_fwd_sel[0]=1, proving youngest wins.
REQ-041 Load rd=4 in stage 0 with i_flush=1 and i_advance=1 -> next cycle rs1=4 gives o_stall=0 and o_fwd_sel[0]=0.
REQ-042 rs1=rs2=0 with rd=0 writers in all stages -> sel=0, stall=0; i_advance=0 for 5 cycles -> entries and counters unchanged.
REQ-043 Assert i_rst asynchronously during a load-use stall -> o_stall=0 before the next edge, counters=0; CNT_W=2 with 5 stalls -> o_stall_cycles saturates at 3.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and defaults for the branch hazard scoreboard and its per-operand matchers.
package hazard_pkg;

    localparam int FWD_RF         = 0;
    localparam int DEF_DEPTH      = 3;
    localparam int DEF_LOAD_READY = 2;
    localparam int DEF_ALU_READY  = 0;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       reg_write;
        logic       is_load;
    } entry_t;

    // Select code 0 is the register file, k is stage k-1, so DEPTH+1 codes are needed.
    function automatic int sel_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/hazard_src_match.sv
// Youngest-producer search for one ID source operand, yielding a forward select or a stall request.
module hazard_src_match
    import hazard_pkg::*;
#(
    parameter int DEPTH      = DEF_DEPTH,
    parameter int LOAD_READY = DEF_LOAD_READY,
    parameter int ALU_READY  = DEF_ALU_READY,
    localparam int SEL_W     = sel_w(DEPTH)
) (
    input  logic                   i_rs_used,
    input  logic [4:0]             i_rs,
    input  entry_t [DEPTH-1:0]     i_entries,
    output logic [SEL_W-1:0]       o_sel,
    output logic                   o_stall
);

    logic w_found;
    logic w_load;
    int   w_idx;

    // Scan oldest to youngest so the lowest matching index is the one that survives.
    always_comb begin
        w_found = 1'b0;
        w_load  = 1'b0;
        w_idx   = 0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (i_entries[k].valid && i_entries[k].reg_write &&
                (i_entries[k].rd != 5'd0) && (i_entries[k].rd == i_rs) && i_rs_used) begin
                w_found = 1'b1;
                w_load  = i_entries[k].is_load;
                w_idx   = k;
            end
        end
    end

    always_comb begin
        o_sel   = SEL_W'(FWD_RF);
        o_stall = 1'b0;
        if (w_found) begin
            if (w_idx >= (w_load ? LOAD_READY : ALU_READY)) begin
                o_sel = SEL_W'(w_idx + 1);
            end else begin
                o_stall = 1'b1;
            end
        end
    end

endmodule

// File: rtl/branch_hazard_scoreboard.sv
// In-flight destination tracker for the ID stage: forwarding selects, load-use stall and statistics.
module branch_hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NUM_SRC    = 2,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int LOAD_READY = DEF_LOAD_READY,
    parameter int ALU_READY  = DEF_ALU_READY,
    parameter int CNT_W      = 16,
    localparam int SEL_W     = sel_w(DEPTH)
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [NUM_SRC*5-1:0]     i_id_rs,
    input  logic [NUM_SRC-1:0]       i_id_rs_used,
    input  logic                     i_issue_valid,
    input  logic [4:0]               i_issue_rd,
    input  logic                     i_issue_reg_write,
    input  logic                     i_issue_is_load,
    input  logic                     i_advance,
    input  logic                     i_flush,
    output logic [NUM_SRC*SEL_W-1:0] o_fwd_sel,
    output logic                     o_stall,
    output logic [CNT_W-1:0]         o_stall_cycles,
    output logic [CNT_W-1:0]         o_fwd_events
);

    logic [DEPTH-1:0]            r_valid;
    logic [DEPTH-1:0][4:0]       r_rd;
    logic [DEPTH-1:0]            r_reg_write;
    logic [DEPTH-1:0]            r_is_load;
    logic [CNT_W-1:0]            r_stall_cnt;
    logic [CNT_W-1:0]            r_fwd_cnt;

    entry_t [DEPTH-1:0]          w_entries;
    logic   [DEPTH-1:0]          w_valid_sq;
    logic   [NUM_SRC-1:0][SEL_W-1:0] w_sel;
    logic   [NUM_SRC-1:0]        w_src_stall;
    logic                        w_stall;
    logic                        w_issue;
    logic                        w_fwd_any;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            w_entries[k].valid     = r_valid[k];
            w_entries[k].rd        = r_rd[k];
            w_entries[k].reg_write = r_reg_write[k];
            w_entries[k].is_load   = r_is_load[k];
        end
    end

    for (genvar n = 0; n < NUM_SRC; n++) begin : g_src
        hazard_src_match #(
            .DEPTH      (DEPTH),
            .LOAD_READY (LOAD_READY),
            .ALU_READY  (ALU_READY)
        ) u_match (
            .i_rs_used (i_id_rs_used[n]),
            .i_rs      (i_id_rs[5*n +: 5]),
            .i_entries (w_entries),
            .o_sel     (w_sel[n]),
            .o_stall   (w_src_stall[n])
        );
    end

    assign w_stall   = |w_src_stall;
    assign o_stall   = w_stall & ~i_rst;
    assign o_fwd_sel = (w_stall || i_rst) ? '0 : w_sel;
    assign w_fwd_any = |o_fwd_sel;
    assign w_issue   = i_issue_valid & ~w_stall & ~i_flush;

    // A flushed stage-0 entry is squashed before it moves on, so it never reaches stage 1.
    always_comb begin
        w_valid_sq    = r_valid;
        w_valid_sq[0] = r_valid[0] & ~i_flush;
    end

    // Stage boundary: ID -> stage 0, stage k-1 -> stage k
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_valid <= '0;
        end else if (i_advance) begin
            for (int k = 1; k < DEPTH; k++) begin
                r_valid[k] <= w_valid_sq[k-1];
            end
            r_valid[0] <= w_issue;
        end else if (i_flush) begin
            r_valid[0] <= 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_advance) begin
            for (int k = 1; k < DEPTH; k++) begin
                r_rd[k]        <= r_rd[k-1];
                r_reg_write[k] <= r_reg_write[k-1];
                r_is_load[k]   <= r_is_load[k-1];
            end
            r_rd[0]        <= i_issue_rd;
            r_reg_write[0] <= i_issue_reg_write;
            r_is_load[0]   <= i_issue_is_load;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_stall_cnt <= '0;
            r_fwd_cnt   <= '0;
        end else begin
            if (w_stall && i_advance) begin
                r_stall_cnt <= sat_inc(r_stall_cnt);
            end
            if (i_issue_valid && i_advance && !w_stall && w_fwd_any) begin
                r_fwd_cnt <= sat_inc(r_fwd_cnt);
            end
        end
    end

    assign o_stall_cycles = r_stall_cnt;
    assign o_fwd_events   = r_fwd_cnt;

endmodule

// File: tb/tb_branch_hazard_scoreboard.sv
// Directed and random stimulus for branch_hazard_scoreboard against a queue-style pipeline model.
module tb_branch_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  id_rs;
    logic [1:0]  rs_used;
    logic        iv, adv, fl, irw, ild;
    logic [4:0]  ird;
    logic [3:0]  fwd_sel, fwd_sel_s;
    logic        stall, stall_s;
    logic [15:0] sc, fe;
    logic [1:0]  sc_s, fe_s;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit v;
        int rd;
        bit rw;
        bit ld;
    } ent_t;

    ent_t pipe[3];
    int   m_sc, m_fe;
    int   exp_sel[2];
    bit   exp_stall;

    always #5 clk = ~clk;

    branch_hazard_scoreboard dut (
        .i_clk(clk), .i_rst(rst), .i_id_rs(id_rs), .i_id_rs_used(rs_used),
        .i_issue_valid(iv), .i_issue_rd(ird), .i_issue_reg_write(irw), .i_issue_is_load(ild),
        .i_advance(adv), .i_flush(fl), .o_fwd_sel(fwd_sel), .o_stall(stall),
        .o_stall_cycles(sc), .o_fwd_events(fe)
    );

    branch_hazard_scoreboard #(.CNT_W(2)) dut_sat (
        .i_clk(clk), .i_rst(rst), .i_id_rs(id_rs), .i_id_rs_used(rs_used),
        .i_issue_valid(iv), .i_issue_rd(ird), .i_issue_reg_write(irw), .i_issue_is_load(ild),
        .i_advance(adv), .i_flush(fl), .o_fwd_sel(fwd_sel_s), .o_stall(stall_s),
        .o_stall_cycles(sc_s), .o_fwd_events(fe_s)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic int sat(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    // Expected outputs: youngest in-flight writer of each operand decides, loads need stage >= 2.
    function automatic void model_eval();
        int  rs;
        bit  found;
        exp_stall = 1'b0;
        for (int n = 0; n < 2; n++) begin
            exp_sel[n] = 0;
            rs = (n == 0) ? int'(id_rs[4:0]) : int'(id_rs[9:5]);
            found = 1'b0;
            if (rs != 0 && rs_used[n]) begin
                for (int k = 0; k < 3; k++) begin
                    if (!found && pipe[k].v && pipe[k].rw && pipe[k].rd == rs) begin
                        found = 1'b1;
                        if (k >= (pipe[k].ld ? 2 : 0)) exp_sel[n] = k + 1;
                        else exp_stall = 1'b1;
                    end
                end
            end
        end
        if (exp_stall) begin
            exp_sel[0] = 0;
            exp_sel[1] = 0;
        end
    endfunction

    function automatic void model_update();
        bit any;
        any = (exp_sel[0] != 0) || (exp_sel[1] != 0);
        if (adv) begin
            if (exp_stall) m_sc++;
            if (iv && !exp_stall && any) m_fe++;
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            if (fl) pipe[1].v = 1'b0;
            pipe[0] = '{v: (iv && !exp_stall && !fl), rd: int'(ird), rw: irw, ld: ild};
        end else if (fl) begin
            pipe[0].v = 1'b0;
        end
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 3; k++) pipe[k] = '{v: 1'b0, rd: 0, rw: 1'b0, ld: 1'b0};
        m_sc = 0;
        m_fe = 0;
    endfunction

    task automatic drive(input int rs0, input int rs1, input logic [1:0] used, input logic v,
                         input int rd, input logic rw, input logic ld, input logic a, input logic f);
        id_rs   = {5'(rs1), 5'(rs0)};
        rs_used = used;
        iv      = v;
        ird     = 5'(rd);
        irw     = rw;
        ild     = ld;
        adv     = a;
        fl      = f;
        #1;
        model_eval();
        check("sel0", 32'(fwd_sel[1:0]), 32'(exp_sel[0]));
        check("sel1", 32'(fwd_sel[3:2]), 32'(exp_sel[1]));
        check("stall", 32'(stall), 32'(exp_stall));
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
        check("stall_cycles", 32'(sc), 32'(sat(m_sc, 16)));
        check("fwd_events", 32'(fe), 32'(sat(m_fe, 16)));
        check("stall_cycles_w2", 32'(sc_s), 32'(sat(m_sc, 2)));
        check("fwd_events_w2", 32'(fe_s), 32'(sat(m_fe, 2)));
    endtask

    task automatic do_reset();
        iv  = 1'b0;
        adv = 1'b0;
        fl  = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_sel", 32'(fwd_sel), 32'd0);
        check("rst_stall_cycles", 32'(sc), 32'd0);
        check("rst_fwd_events", 32'(fe), 32'd0);
        model_reset();
        rst = 1'b0;
    endtask

    initial begin
        int nst;
        rst = 1'b0; id_rs = '0; rs_used = '0; iv = 1'b0; ird = '0;
        irw = 1'b0; ild = 1'b0; adv = 1'b0; fl = 1'b0;
        model_reset();
        do_reset();

        // ALU producer forwarded from stage 0
        drive(0, 0, 2'b00, 1, 5, 1, 0, 1, 0); tick();
        drive(5, 0, 2'b01, 1, 2, 1, 0, 1, 0);
        check("alu_fwd_sel0", 32'(fwd_sel[1:0]), 32'd1);
        check("alu_fwd_stall", 32'(stall), 32'd0);
        tick();

        // Load-use: two stall cycles then forward from stage 2
        do_reset();
        drive(0, 0, 2'b00, 1, 7, 1, 1, 1, 0); tick();
        drive(0, 7, 2'b10, 1, 8, 1, 0, 1, 0);
        check("ld_stall_a", 32'(stall), 32'd1); tick();
        drive(0, 7, 2'b10, 1, 8, 1, 0, 1, 0);
        check("ld_stall_b", 32'(stall), 32'd1); tick();
        drive(0, 7, 2'b10, 1, 8, 1, 0, 1, 0);
        check("ld_fwd_sel1", 32'(fwd_sel[3:2]), 32'd3);
        check("ld_stall_done", 32'(stall), 32'd0);
        check("ld_stall_cycles", 32'(sc), 32'd2);
        tick();

        // Youngest of two matching producers wins
        drive(0, 0, 2'b00, 1, 9, 1, 0, 1, 0); tick();
        drive(0, 0, 2'b00, 1, 1, 1, 0, 1, 0); tick();
        drive(0, 0, 2'b00, 1, 9, 1, 0, 1, 0); tick();
        drive(9, 0, 2'b01, 0, 0, 0, 0, 0, 0);
        check("youngest_sel0", 32'(fwd_sel[1:0]), 32'd1);
        tick();

        // Flush with advance squashes a load in stage 0, and wins over a same-cycle issue
        drive(0, 0, 2'b00, 1, 4, 1, 1, 1, 0); tick();
        drive(0, 0, 2'b00, 1, 4, 1, 1, 1, 1); tick();
        drive(4, 0, 2'b01, 0, 0, 0, 0, 1, 0);
        check("flush_stall", 32'(stall), 32'd0);
        check("flush_sel0", 32'(fwd_sel[1:0]), 32'd0);
        tick();

        // rd=0 writers never match; advance=0 holds state and counters
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 2'b00, 1, 0, 1, 1'(i), 1, 0); tick();
        end
        drive(0, 0, 2'b11, 0, 0, 0, 0, 1, 0);
        check("x0_sel", 32'(fwd_sel), 32'd0);
        check("x0_stall", 32'(stall), 32'd0);
        tick();
        drive(0, 0, 2'b00, 1, 6, 1, 1, 1, 0); tick();
        for (int i = 0; i < 5; i++) begin
            drive(6, 0, 2'b01, 1, 3, 1, 0, 0, 0);
            check("hold_stall", 32'(stall), 32'd1);
            tick();
        end
        drive(6, 0, 2'b01, 1, 3, 1, 0, 1, 0); tick();
        drive(6, 0, 2'b01, 1, 3, 1, 0, 1, 0); tick();
        drive(6, 0, 2'b01, 0, 0, 0, 0, 1, 0);
        check("hold_release_sel0", 32'(fwd_sel[1:0]), 32'd3);
        tick();

        // Asynchronous reset in the middle of a load-use stall
        drive(0, 0, 2'b00, 1, 7, 1, 1, 1, 0); tick();
        drive(7, 0, 2'b01, 1, 2, 1, 0, 1, 0);
        check("pre_rst_stall", 32'(stall), 32'd1);
        do_reset();
        drive(0, 0, 2'b00, 1, 5, 1, 0, 1, 0); tick();
        drive(5, 0, 2'b01, 0, 0, 0, 0, 1, 0);
        check("post_rst_sel0", 32'(fwd_sel[1:0]), 32'd1);
        tick();

        // Narrow counter saturates at 3 after five stall cycles
        do_reset();
        nst = 0;
        for (int it = 0; it < 3; it++) begin
            drive(0, 0, 2'b00, 1, 7, 1, 1, 1, 0); tick();
            for (int s = 0; s < 2; s++) begin
                if (nst < 5) begin
                    drive(7, 0, 2'b01, 1, 3, 1, 0, 1, 0); tick();
                    nst++;
                end
            end
        end
        check("sat_w2_stall_cycles", 32'(sc_s), 32'd3);
        check("sat_w16_stall_cycles", 32'(sc), 32'd5);

        // Random traffic over a small register range to provoke frequent hazards
        for (int i = 0; i < 600; i++) begin
            if (i == 300) do_reset();
            drive(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), 2'($urandom),
                  1'($urandom), int'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0),
                  1'($urandom), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 9) == 0));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
